// File: rtl/axis_moving_window_integrator.sv
// Pan-Tompkins moving-window integrator. It averages the last 2**LOG2_WIN accepted squared
// samples and returns one truncated average per accepted beat through a single output register.
module axis_moving_window_integrator #(
  parameter  int DATA_W   = 32,
  parameter  int LOG2_WIN = 5,
  localparam int SUM_W    = DATA_W + LOG2_WIN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  input  logic              m_axis_tready,
  output logic              win_full
);

  localparam int WIN_LEN = 1 << LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] LAST_IDX = '1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [DATA_W-1:0]   win_buf_q [WIN_LEN];
  logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                rdy_en_q;
  logic                win_full_q;
  state_e              state_q;
  logic [DATA_W-1:0]   oldest;
  logic                accept;

  // Truncating divide by the window length; SUM_W guarantees the quotient fits DATA_W.
  function automatic logic [DATA_W-1:0] window_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:LOG2_WIN];
  endfunction

  assign s_axis_tready = rdy_en_q & (~m_tvalid_q | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign win_full      = win_full_q;

  assign oldest = win_buf_q[wr_ptr_q];

  always_comb begin
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    if (accept) begin
      // The buffer entry leaving the window is always part of sum_q, so this never underflows.
      sum_d      = sum_q + SUM_W'(s_axis_tdata) - SUM_W'(oldest);
      wr_ptr_d   = wr_ptr_q + LOG2_WIN'(1);
      m_tdata_d  = window_avg(sum_d);
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      state_q    <= FILL;
      win_full_q <= 1'b0;
      for (int i = 0; i < WIN_LEN; i++) begin
        win_buf_q[i] <= '0;
      end
    end else begin
      rdy_en_q   <= 1'b1;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      if (accept) begin
        win_buf_q[wr_ptr_q] <= s_axis_tdata;
      end
      // During FILL the write pointer doubles as the accepted-sample count.
      case (state_q)
        FILL: begin
          if (accept && (wr_ptr_q == LAST_IDX)) begin
            state_q    <= RUN;
            win_full_q <= 1'b1;
          end
        end
        RUN: begin
          win_full_q <= 1'b1;
        end
        default: begin
          state_q    <= FILL;
          win_full_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
